// File: rtl/ucore_port_ctrl.sv
// rtl/ucore_port_ctrl.sv - core request channel to NCH one-hot peripheral ports
// Adds an ack timeout with error response and merged edge-latched channel interrupts.
module ucore_port_ctrl #(
  parameter int NCH = 8,
  parameter int DW = 8,
  parameter int TIMEOUT = 255,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          core_req_valid,
  output logic          core_req_ready,
  input  logic          core_req_rnw,
  input  logic [CW-1:0] core_req_chan,
  input  logic [DW-1:0] core_req_wdata,
  output logic          core_rsp_valid,
  output logic [DW-1:0] core_rsp_rdata,
  output logic          core_rsp_err,
  input  logic [NCH-1:0] irq_mask,
  input  logic [NCH-1:0] irq_clr,
  output logic [NCH-1:0] irq_pending,
  output logic          core_irq,
  output logic [NCH-1:0] port_rcen,
  output logic [NCH-1:0] port_wcen,
  output logic [DW-1:0] port_wdata,
  input  logic [DW-1:0] port_rdata,
  input  logic          port_rack,
  input  logic          port_wack,
  input  logic [NCH-1:0] port_irq
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t         state_q, state_d;
  logic           ready_q, ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;
  logic [NCH-1:0] rcen_q, rcen_d;
  logic [NCH-1:0] wcen_q, wcen_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] irq_prev_q, irq_prev_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic           core_irq_q, core_irq_d;

  logic           accept;
  logic           chan_ok;
  logic           ack;
  logic           tmo;
  logic [NCH-1:0] chan_onehot;
  logic [TW-1:0]  cnt_inc;

  always_comb begin
    accept      = core_req_valid & ready_q;
    chan_ok     = {{(32-CW){1'b0}}, core_req_chan} < NCH;
    chan_onehot = {{(NCH-1){1'b0}}, 1'b1} << core_req_chan;
    ack         = ((state_q == READ) & port_rack) | ((state_q == WRITE) & port_wack);
    cnt_inc     = cnt_q + 1'b1;
    // Timeout fires on the cycle the counter would step onto TIMEOUT; ack has priority.
    tmo         = (TIMEOUT != 0) && (cnt_inc == TW'(TIMEOUT));

    state_d     = state_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    rcen_d      = rcen_q;
    wcen_d      = wcen_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          cnt_d   = '0;
          if (!chan_ok) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (core_req_rnw) begin
            state_d = READ;
            rcen_d  = chan_onehot;
          end else begin
            state_d = WRITE;
            wcen_d  = chan_onehot;
            wdata_d = core_req_wdata;
          end
        end
      end
      READ, WRITE: begin
        if (ack || tmo) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !ack;
          rsp_rdata_d = (ack && state_q == READ) ? port_rdata : '0;
          rcen_d      = '0;
          wcen_d      = '0;
          wdata_d     = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    irq_prev_d = port_irq;
    pending_d  = (pending_q & ~irq_clr) | (port_irq & ~irq_prev_q);
    core_irq_d = |(pending_q & irq_mask);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rcen_q      <= '0;
      wcen_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      irq_prev_q  <= '0;
      pending_q   <= '0;
      core_irq_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rcen_q      <= rcen_d;
      wcen_q      <= wcen_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      irq_prev_q  <= irq_prev_d;
      pending_q   <= pending_d;
      core_irq_q  <= core_irq_d;
    end
  end

  assign core_req_ready = ready_q;
  assign core_rsp_valid = rsp_valid_q;
  assign core_rsp_rdata = rsp_rdata_q;
  assign core_rsp_err   = rsp_err_q;
  assign irq_pending    = pending_q;
  assign core_irq       = core_irq_q;
  assign port_rcen      = rcen_q;
  assign port_wcen      = wcen_q;
  assign port_wdata     = wdata_q;

endmodule

// File: tb/tb_ucore_port_ctrl.sv
// tb/tb_ucore_port_ctrl.sv - directed bench for ucore_port_ctrl (NCH=10, TIMEOUT=4)
module tb_ucore_port_ctrl;
  logic       clk;
  logic       areset;
  logic       core_req_valid;
  logic       core_req_ready;
  logic       core_req_rnw;
  logic [3:0] core_req_chan;
  logic [7:0] core_req_wdata;
  logic       core_rsp_valid;
  logic [7:0] core_rsp_rdata;
  logic       core_rsp_err;
  logic [9:0] irq_mask;
  logic [9:0] irq_clr;
  logic [9:0] irq_pending;
  logic       core_irq;
  logic [9:0] port_rcen;
  logic [9:0] port_wcen;
  logic [7:0] port_wdata;
  logic [7:0] port_rdata;
  logic       port_rack;
  logic       port_wack;
  logic [9:0] port_irq;

  int total = 0;
  int bad = 0;

  int         en_cnt;
  logic [9:0] en_val;
  logic       other_seen;
  int         rsp_cyc;
  logic [7:0] rsp_rd;
  logic       rsp_er;
  logic       rdy_at_rsp;
  logic       wd_bad;
  logic       post_valid;
  logic       post_ready;
  logic [7:0] post_rdata;
  logic       post_err;

  ucore_port_ctrl #(.NCH(10), .DW(8), .TIMEOUT(4)) dut (
    .clk(clk), .areset(areset),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_rnw(core_req_rnw), .core_req_chan(core_req_chan),
    .core_req_wdata(core_req_wdata),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
    .core_rsp_err(core_rsp_err),
    .irq_mask(irq_mask), .irq_clr(irq_clr), .irq_pending(irq_pending),
    .core_irq(core_irq),
    .port_rcen(port_rcen), .port_wcen(port_wcen), .port_wdata(port_wdata),
    .port_rdata(port_rdata), .port_rack(port_rack), .port_wack(port_wack),
    .port_irq(port_irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Issues one request and watches it to completion; ack_at is the cycle after
  // accept on which the matching ack is driven (0 = never). The opposite ack
  // is held high throughout to show it is ignored.
  task automatic txn(input logic rnw, input logic [3:0] chan, input logic [7:0] wd,
                     input int ack_at, input logic [7:0] rd);
    en_cnt = 0; en_val = '0; other_seen = 0; rsp_cyc = -1;
    rsp_rd = '0; rsp_er = 0; rdy_at_rsp = 1; wd_bad = 0;
    core_req_valid = 1; core_req_rnw = rnw; core_req_chan = chan; core_req_wdata = wd;
    port_rdata = 8'hEE;
    tick;
    core_req_valid = 0; core_req_wdata = 8'h00;
    for (int c = 1; c < 30 && rsp_cyc < 0; c++) begin
      if ((rnw ? port_rcen : port_wcen) != '0) begin
        en_cnt++;
        en_val = rnw ? port_rcen : port_wcen;
        if (!rnw && port_wdata != wd) wd_bad = 1;
      end
      if ((rnw ? port_wcen : port_rcen) != '0) other_seen = 1;
      if (core_rsp_valid) begin
        rsp_cyc = c; rsp_rd = core_rsp_rdata; rsp_er = core_rsp_err; rdy_at_rsp = core_req_ready;
      end
      port_rack  = rnw ? (c == ack_at) : 1'b1;
      port_wack  = rnw ? 1'b1 : (c == ack_at);
      port_rdata = (c == ack_at) ? rd : 8'hEE;
      tick;
    end
    port_rack = 0; port_wack = 0; port_rdata = 8'hEE;
    post_valid = core_rsp_valid; post_ready = core_req_ready;
    post_rdata = core_rsp_rdata; post_err = core_rsp_err;
  endtask

  task automatic expect_txn(input string tag, input int x_cnt, input logic [9:0] x_val,
                            input int x_cyc, input logic [7:0] x_rd, input logic x_err);
    check({tag, ".en_cycles"}, 32'(en_cnt), 32'(x_cnt));
    check({tag, ".en_value"}, 32'(en_val), 32'(x_val));
    check({tag, ".other_en"}, 32'(other_seen), 32'(0));
    check({tag, ".wdata_hold"}, 32'(wd_bad), 32'(0));
    check({tag, ".rsp_cycle"}, 32'(rsp_cyc), 32'(x_cyc));
    check({tag, ".rsp_rdata"}, 32'(rsp_rd), 32'(x_rd));
    check({tag, ".rsp_err"}, 32'(rsp_er), 32'(x_err));
    check({tag, ".ready_at_rsp"}, 32'(rdy_at_rsp), 32'(0));
    check({tag, ".post_valid"}, 32'(post_valid), 32'(0));
    check({tag, ".post_ready"}, 32'(post_ready), 32'(1));
    check({tag, ".post_rdata"}, 32'(post_rdata), 32'(0));
    check({tag, ".post_err"}, 32'(post_err), 32'(0));
  endtask

  initial begin
    clk = 0; areset = 1;
    core_req_valid = 0; core_req_rnw = 0; core_req_chan = '0; core_req_wdata = '0;
    irq_mask = '0; irq_clr = '0; port_rdata = 8'hEE; port_rack = 0; port_wack = 0; port_irq = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 32'(core_req_ready), 32'(0));
    check("rst.rcen", 32'(port_rcen), 32'(0));
    check("rst.wcen", 32'(port_wcen), 32'(0));
    check("rst.wdata", 32'(port_wdata), 32'(0));
    check("rst.rsp_valid", 32'(core_rsp_valid), 32'(0));
    check("rst.pending", 32'(irq_pending), 32'(0));
    check("rst.core_irq", 32'(core_irq), 32'(0));
    areset = 0;
    check("rel.ready_hold", 32'(core_req_ready), 32'(0));
    tick;
    check("rel.ready", 32'(core_req_ready), 32'(1));

    txn(1'b1, 4'd3, 8'h00, 3, 8'hA5);
    expect_txn("rd_ch3", 3, 10'h008, 4, 8'hA5, 1'b0);

    txn(1'b0, 4'd0, 8'h3C, 1, 8'h00);
    expect_txn("wr_ch0", 1, 10'h001, 2, 8'h00, 1'b0);

    txn(1'b1, 4'd1, 8'h00, 0, 8'h77);
    expect_txn("tmo_ch1", 4, 10'h002, 5, 8'h00, 1'b1);

    txn(1'b1, 4'd1, 8'h00, 4, 8'h5A);
    expect_txn("tmo_race", 4, 10'h002, 5, 8'h5A, 1'b0);

    txn(1'b0, 4'd9, 8'h81, 2, 8'h00);
    expect_txn("wr_ch9", 2, 10'h200, 3, 8'h00, 1'b0);

    txn(1'b1, 4'd10, 8'h00, 0, 8'h99);
    expect_txn("bad_ch10", 0, 10'h000, 1, 8'h00, 1'b1);

    irq_mask = 10'h020; port_irq = 10'h020;
    check("irq.pre", 32'(irq_pending), 32'(0));
    tick;
    check("irq.set", 32'(irq_pending), 32'h020);
    check("irq.core_lag", 32'(core_irq), 32'(0));
    tick;
    check("irq.core", 32'(core_irq), 32'(1));
    irq_clr = 10'h020;
    tick;
    irq_clr = '0;
    check("irq.clr", 32'(irq_pending), 32'(0));
    tick;
    check("irq.core_clr", 32'(core_irq), 32'(0));
    repeat (2) tick;
    check("irq.level_hold", 32'(irq_pending), 32'(0));
    port_irq = '0;
    tick;
    port_irq = 10'h020; irq_clr = 10'h020;
    tick;
    irq_clr = '0;
    check("irq.set_wins", 32'(irq_pending), 32'h020);
    irq_mask = '0;
    repeat (2) tick;
    check("irq.masked", 32'(core_irq), 32'(0));
    check("irq.mask_keeps", 32'(irq_pending), 32'h020);
    irq_mask = 10'h020;
    repeat (2) tick;
    check("irq.unmasked", 32'(core_irq), 32'(1));
    port_irq = '0; irq_clr = 10'h020;
    tick;
    irq_clr = '0;

    core_req_valid = 1; core_req_rnw = 1; core_req_chan = 4'd2;
    tick;
    core_req_valid = 0;
    check("arst.rcen_pre", 32'(port_rcen), 32'h004);
    tick;
    #1 areset = 1;
    #1;
    check("arst.rcen_drop", 32'(port_rcen), 32'(0));
    check("arst.ready", 32'(core_req_ready), 32'(0));
    tick;
    check("arst.no_rsp", 32'(core_rsp_valid), 32'(0));
    areset = 0;
    tick;
    check("arst.ready_back", 32'(core_req_ready), 32'(1));
    check("arst.no_rsp_after", 32'(core_rsp_valid), 32'(0));
    txn(1'b1, 4'd2, 8'h00, 1, 8'h3E);
    expect_txn("arst_rd", 1, 10'h004, 2, 8'h3E, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
